// File: rtl/cfg_loader_pkg.sv
// Shared types, CRC constants and stream-geometry helpers for the fabric config loader.
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE,
    ERROR
  } cfg_state_e;

  localparam int          CRC_W    = 16;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  function automatic int cfg_total(input int io_w, input int cb1_w, input int cblr_w,
                                   input int sel_w, input int lut_w, input int sb_w);
    return io_w + cb1_w + cblr_w + sel_w + lut_w + sb_w;
  endfunction

  function automatic int cfg_data_beats(input int total, input int word_w);
    return (total + word_w - 1) / word_w;
  endfunction

  function automatic int cfg_crc_beats(input int word_w);
    return (CRC_W + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/cfg_crc16.sv
// CRC-16-CCITT over one WORD_W-bit beat per cycle, MSB-first; clr reloads the init value.
module cfg_crc16
  import cfg_loader_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [WORD_W-1:0] data,
  output logic [15:0]       crc
);

  logic [15:0] crc_nxt;

  always_comb begin
    crc_nxt = crc;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (crc_nxt[15] ^ data[i]) crc_nxt = {crc_nxt[14:0], 1'b0} ^ CRC_POLY;
      else                       crc_nxt = {crc_nxt[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   crc <= '0;
    else if (clr) crc <= CRC_INIT;
    else if (en)  crc <= crc_nxt;
  end

endmodule

// File: rtl/cfg_loader.sv
// Streams a fabric configuration into a shadow register and commits it atomically.
// Optional CRC check of the stream is enabled with CFG_LOADER_CRC_EN.
module cfg_loader
  import cfg_loader_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int IO_W   = 20,
  parameter int CB1_W  = 300,
  parameter int CBLR_W = 120,
  parameter int SEL_W  = 9,
  parameter int LUT_W  = 144,
  parameter int SB_W   = 240
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [IO_W-1:0]   iostream,
  output logic [CB1_W-1:0]  cbstream1,
  output logic [CBLR_W-1:0] cbstreamleft_or_right,
  output logic [SEL_W-1:0]  clb_mux_sel,
  output logic [LUT_W-1:0]  bitstream,
  output logic [SB_W-1:0]   sbstream,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic              fabric_en
);

  localparam int TOTAL      = cfg_total(IO_W, CB1_W, CBLR_W, SEL_W, LUT_W, SB_W);
  localparam int DATA_BEATS = cfg_data_beats(TOTAL, WORD_W);
`ifdef CFG_LOADER_CRC_EN
  localparam int CRC_BEATS  = cfg_crc_beats(WORD_W);
`else
  localparam int CRC_BEATS  = 0;
`endif
  localparam int ALL_BEATS  = DATA_BEATS + CRC_BEATS;
  localparam int CW         = $clog2(ALL_BEATS + 1);
  // bits of the final data beat that still belong to the config; the rest is pad
  localparam int REM        = TOTAL - (DATA_BEATS - 1) * WORD_W;

  localparam logic [CW-1:0] LAST_BEAT  = CW'(ALL_BEATS - 1);
  localparam logic [CW-1:0] LAST_DATA  = CW'(DATA_BEATS - 1);
  localparam logic [CW-1:0] DATA_CNT   = CW'(DATA_BEATS);

  cfg_state_e       state, state_nxt;
  logic [CW-1:0]    beat_cnt;
  logic [TOTAL-1:0] shadow;
  logic [TOTAL-1:0] active;
  logic             cfg_loaded;
  logic             accept, data_beat, pass, commit;

  assign cfg_ready = (state == LOAD);
  assign accept    = cfg_valid && cfg_ready && !cfg_start;
  assign data_beat = accept && (beat_cnt < DATA_CNT);
  assign commit    = (state == CHECK) && pass && !cfg_start;
  assign cfg_done  = (state == DONE);
  assign cfg_err   = (state == ERROR);
  assign fabric_en = cfg_loaded && !(state inside {LOAD, CHECK});

  assign {iostream, cbstream1, cbstreamleft_or_right, clb_mux_sel, bitstream, sbstream} = active;

`ifdef CFG_LOADER_CRC_EN
  localparam int RXW = CRC_BEATS * WORD_W;

  logic [15:0]    crc;
  logic [RXW-1:0] rx_crc;

  cfg_crc16 #(.WORD_W(WORD_W)) u_crc (
    .clk   (clk),
    .reset (reset),
    .clr   (cfg_start),
    .en    (data_beat),
    .data  (cfg_data),
    .crc   (crc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    rx_crc <= '0;
    else if (cfg_start)            rx_crc <= '0;
    else if (accept && !data_beat) rx_crc <= (rx_crc << WORD_W) | RXW'(cfg_data);
  end

  // received CRC is left-aligned in its beats; pad sits in the low bits
  assign pass = (crc == rx_crc[RXW-1 -: 16]);
`else
  assign pass = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    if (cfg_start) state_nxt = LOAD;
    else begin
      case (state)
        LOAD:    if (accept && beat_cnt == LAST_BEAT) state_nxt = CHECK;
        CHECK:   state_nxt = pass ? DONE : ERROR;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt <= '0;
      shadow   <= '0;
    end else if (cfg_start) begin
      beat_cnt <= '0;
      shadow   <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + CW'(1);
      if (beat_cnt == LAST_DATA)
        shadow <= {shadow[TOTAL-REM-1:0], cfg_data[WORD_W-1 -: REM]};
      else if (data_beat)
        shadow <= {shadow[TOTAL-WORD_W-1:0], cfg_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active     <= '0;
      cfg_loaded <= 1'b0;
    end else if (commit) begin
      active     <= shadow;
      cfg_loaded <= 1'b1;
    end
  end

endmodule

// File: doc/cfg_loader.md
CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 8, meaning config word width per beat (1..32).
REQ-002 SHALL have parameters IO_W=20, CB1_W=300, CBLR_W=120, SEL_W=9, LUT_W=144, SB_W=240, giving the section widths for the 3x3 fabric.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port cfg_start, input, 1: single-cycle pulse that begins a load.
REQ-006 SHALL have ports cfg_data (input, WORD_W), cfg_valid (input, 1) and cfg_ready (output, 1): a valid/ready beat stream.
REQ-007 SHALL have outputs iostream [IO_W], cbstream1 [CB1_W], cbstreamleft_or_right [CBLR_W], clb_mux_sel [SEL_W], bitstream [LUT_W] and sbstream [SB_W], carrying the active fabric configuration.
REQ-008 SHALL have outputs cfg_done (1), cfg_err (1) and fabric_en (1).

Function
REQ-009 SHALL implement the FSM states IDLE, LOAD, CHECK, DONE and ERROR.
REQ-010 SHALL move from any state to LOAD on cfg_start; LOAD clears the beat counter, the shadow register and the CRC.
REQ-011 SHALL hold cfg_ready=1 only in LOAD; a beat is accepted when cfg_valid and cfg_ready are both 1; gaps in cfg_valid are allowed.
REQ-012 SHALL define TOTAL = sum of the section widths and DATA_BEATS = ceil(TOTAL/WORD_W); with the defaults, TOTAL=833 and DATA_BEATS=105.
REQ-013 SHALL shift beats MSB-first into a shadow of the concatenation {iostream, cbstream1, cbstreamleft_or_right, clb_mux_sel, bitstream, sbstream}; the low pad bits of the final beat are discarded.
REQ-014 SHALL move to CHECK on the edge that accepts the last beat of the stream.
REQ-015 SHALL, on the edge after CHECK, either copy the shadow atomically to the active outputs and enter DONE (pass), or leave the outputs unchanged and enter ERROR (fail).
REQ-016 SHALL make the active outputs change only on a commit, with the new values visible 2 cycles after the last beat is accepted.
REQ-017 SHALL drive cfg_done=1 exactly while in DONE and cfg_err=1 exactly while in ERROR; both clear on cfg_start.
REQ-018 SHALL set a sticky flag cfg_loaded on the first commit; fabric_en = cfg_loaded AND state not in {LOAD, CHECK}.
REQ-019 SHALL treat cfg_start during LOAD or CHECK as an abort plus restart: the shadow is discarded, the active outputs are kept, and no commit occurs.
REQ-020 SHALL ignore cfg_start and an accepted beat in the same cycle as each other: the restart takes priority and the beat is dropped.
REQ-021 SHALL ignore cfg_valid outside LOAD.

Reset
REQ-022 SHALL, while reset=0, set state=IDLE, all six config outputs=0, cfg_ready=0, cfg_done=0, cfg_err=0, cfg_loaded=0, fabric_en=0 and the counter/CRC=0.
REQ-023 SHALL, on reset asserted mid-LOAD, abort immediately with no partial configuration reaching the outputs.

Configuration
REQ-024 SHALL, with CFG_LOADER_CRC_EN defined, expect CRC_BEATS = ceil(16/WORD_W) extra beats after the data.
REQ-025 SHALL, with CFG_LOADER_CRC_EN defined, compute CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) over all data-beat bits including pad bits.
REQ-026 SHALL, with CFG_LOADER_CRC_EN defined, compare the computed CRC in CHECK against the received CRC, MSB-first; a mismatch leads to ERROR.
REQ-027 SHALL, without CFG_LOADER_CRC_EN, have no CRC beats and no CRC logic, with CHECK always passing.

Structure
REQ-028 SHALL place in package cfg_loader_pkg the state enum, the CRC polynomial/init constants, and functions for TOTAL, DATA_BEATS and CRC_BEATS.
REQ-029 SHALL implement the CRC as one sub-module, cfg_crc16, which updates the CRC over one WORD_W-bit beat per cycle with enable and clear.

Verification
REQ-030 SHALL cover: WORD_W=8, no CRC, cfg_start then 105 beats of 0xA5 -> the outputs equal the 840-bit pattern truncated to 833 bits, cfg_done=1 and fabric_en=1, 2 cycles after beat 105.
REQ-031 SHALL cover: CRC enabled, 105 data beats plus a correct 2-beat CRC -> DONE; the same stream with the final CRC beat XOR 0x01 -> cfg_err=1, outputs remain at the prior load, and fabric_en keeps its prior value.
REQ-032 SHALL cover: cfg_valid toggling 1/0 every cycle for the full load -> a result identical to the back-to-back load, with 210 cycles in LOAD.
REQ-033 SHALL cover: after a good load, cfg_start at beat 50 followed by a full new load -> the old outputs held, fabric_en=0 during the reload, then the new values committed.
REQ-034 SHALL cover: reset=0 at beat 60 of the first load -> all outputs 0, fabric_en=0 and cfg_ready=0 asynchronously, before the next clk edge.
REQ-035 SHALL cover: cfg_start and cfg_valid asserted in the same cycle -> the beat is dropped and the counter reads 0 on the next cycle.
